fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage that sits directly upstream of the control path in the single-cycle core.
- Holds the architectural PC and fetches instructions from instruction memory over a request/grant/response handshake with variable latency.
- Presents one instruction at a time to decode/control.
- When the core retires that instruction, consumes the 2-bit pc_src selector plus immediate and rs1 to compute the next PC.
- Flags misaligned jump/branch targets.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- i_clk, input, 1, clock; all logic on rising edge.
- i_rst, input, 1, synchronous active-high reset.
- i_advance, input, 1, core has executed the presented instruction; next-PC inputs are valid this cycle.
- i_pc_src, input, 2, 00 PC+4, 01 PC+imm (branch taken / jal), 10 rs1+imm (jalr), 11 reserved (treated as 00).
- i_imm, input, XLEN, sign-extended immediate.
- i_rs1, input, XLEN, rs1 value for jalr.
- o_imem_req, output, 1, fetch request.
- o_imem_addr, output, XLEN, fetch address (equals o_pc).
- i_imem_gnt, input, 1, memory accepts the request this cycle.
- i_imem_rvalid, input, 1, response data valid.
- i_imem_rdata, input, 32, instruction word.
- o_instr, output, 32, held instruction.
- o_instr_valid, output, 1, o_instr is valid for o_pc.
- o_pc, output, XLEN, PC of the current/fetching instruction.
- o_pc_plus4, output, XLEN, o_pc+4 (link value for jal/jalr).
- o_misaligned, output, 1, sticky fault: a computed target was not 4-byte aligned.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_pc=RESET_PC, state=REQ, o_instr=32'h0000_0013 (nop), o_instr_valid=0, o_misaligned=0.
  - o_imem_req is 1 in the first cycle after reset.
  - Reset overrides every other input in the same cycle. Instruction memory shares i_rst, so no stale response survives reset.
- FSM states are REQ, WAIT, VALID, FAULT.
- REQ:
  - o_imem_req=1, o_imem_addr=o_pc, both held stable until i_imem_gnt=1.
  - On grant, go to WAIT.
- WAIT:
  - o_imem_req=0.
  - On i_imem_rvalid=1, capture i_imem_rdata into o_instr and go to VALID.
  - rvalid is never earlier than the cycle after gnt. Minimum fetch latency is 2 cycles (REQ with gnt, then WAIT with rvalid); o_instr_valid rises the following cycle.
- VALID:
  - o_instr_valid=1; o_instr and o_pc are stable.
  - On i_advance=1, compute the next PC:
    - 00/11: pc+4
    - 01: pc+imm
    - 10: (rs1+imm) & ~1
  - All additions are modulo 2^XLEN; wrap-around is silent (32'hFFFF_FFFC+4 -> 0).
  - If next[1:0]==0: load o_pc=next, clear o_instr_valid, go to REQ.
  - If next[1:0]!=0: o_pc is unchanged, o_misaligned=1, o_instr_valid=0, go to FAULT.
- FAULT:
  - Absorbing state; no requests issued. Exit only by reset.
- Ignored inputs:
  - i_advance is ignored outside VALID.
  - i_imem_rvalid is ignored outside WAIT.
  - i_imem_gnt is ignored outside REQ.
- o_pc_plus4 is combinational o_pc+4 and valid in all states.
- No prefetch: at most one outstanding request. o_pc only changes on advance or reset.

Test Plan:
- Reset sequence:
  - Stimulus: RESET_PC=0; assert i_rst 2 cycles; after release, gnt in cycle 1, rvalid=1 with rdata=32'h0010_0093 in cycle 2.
  - Required: o_imem_req=1 and addr=0 in cycle 1; o_instr_valid=1 with o_instr=32'h0010_0093 in cycle 3; o_pc=0.
- Sequential fetch with delayed grant:
  - Stimulus: i_advance with pc_src=00 at pc=0; gnt withheld 3 cycles.
  - Required: addr=4 held stable all 3 cycles; o_pc=4; o_pc_plus4=8.
- Branch/jal and wrap-around:
  - Stimulus: pc=8, imm=-8, pc_src=01.
  - Required: next fetch addr=0.
  - Stimulus: pc=32'hFFFF_FFFC, pc_src=00.
  - Required: addr=0.
- jalr:
  - Stimulus: rs1=32'h0000_0101, imm=3, pc_src=10.
  - Required: target=32'h104; fetch at 0x104.
  - Stimulus: rs1=0x100, imm=2.
  - Required: o_misaligned=1, FSM in FAULT, o_imem_req stays 0 for 10 cycles, o_pc unchanged.
- Spurious inputs:
  - Stimulus: i_advance pulsed during WAIT; rvalid pulsed during VALID with different data.
  - Required: o_pc and o_instr unchanged.
- Reset mid-operation:
  - Stimulus: i_rst in WAIT or FAULT.
  - Required: next cycle o_pc=RESET_PC, o_misaligned=0, o_instr_valid=0, o_imem_req=1.

Source files
------------

// File: rtl/fetch_unit.sv
// Program counter and single-outstanding instruction fetch stage.
// It holds one instruction for decode and computes the next PC when that
// instruction retires. A misaligned target parks the unit until reset.
module fetch_unit #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_advance,
  input  logic [1:0]      i_pc_src,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic [31:0]     o_instr,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_misaligned
);

  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [ILEN-1:0]   instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic              mis_q, mis_d;
  logic [XLEN-1:0]   target;

  // State register plus registered copies of the handshake/status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      valid_q <= 1'b0;
      req_q   <= 1'b1;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state, next-PC selection and fetch response capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    mis_d   = mis_q;
    target  = '0;

    unique case (i_pc_src)
      2'b01:   target = pc_q + i_imm;
      2'b10:   target = (i_rs1 + i_imm) & ~XLEN'(1);
      default: target = pc_q + XLEN'(4);
    endcase

    case (state_q)
      S_REQ: begin
        if (i_imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          instr_d = i_imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (i_advance) begin
          if (target[1:0] == 2'b00) begin
            pc_d    = target;
            state_d = S_REQ;
          end else begin
            mis_d   = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    // Outputs reflect the state being entered so they come straight from flops
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_VALID);
  end

  assign o_imem_req    = req_q;
  assign o_imem_addr   = pc_q;
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_q + XLEN'(4);
  assign o_instr       = instr_q;
  assign o_instr_valid = valid_q;
  assign o_misaligned  = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table followed by
// randomized traffic checked against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        advance;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_advance     (advance),
    .i_pc_src      (pc_src),
    .i_imm         (imm),
    .i_rs1         (rs1),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_pc          (pc),
    .o_pc_plus4    (pc_plus4),
    .o_misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench always terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        adv;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        ereq;
    logic        evalid;
    logic        emis;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                     input logic a, input logic [1:0] s, input logic [31:0] im,
                     input logic [31:0] r1, input logic ereq, input logic evalid,
                     input logic emis, input logic [31:0] epc, input logic [31:0] einstr);
    vec_t v;
    v.rst = r; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.adv = a; v.src = s;
    v.imm = im; v.rs1 = r1; v.ereq = ereq; v.evalid = evalid; v.emis = emis;
    v.epc = epc; v.einstr = einstr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ereq, input logic evalid,
                           input logic emis, input logic [31:0] epc, input logic [31:0] einstr);
    logic [31:0] ep4;
    ep4 = epc + 32'd4;
    chk({tag, " req"},     32'(imem_req),    32'(ereq));
    chk({tag, " addr"},    imem_addr,        epc);
    chk({tag, " pc"},      pc,               epc);
    chk({tag, " pc_plus4"}, pc_plus4,        ep4);
    chk({tag, " valid"},   32'(instr_valid), 32'(evalid));
    chk({tag, " instr"},   instr,            einstr);
    chk({tag, " mis"},     32'(misaligned),  32'(emis));
  endtask

  // Reference model: what the fetch stage is holding, at transaction level
  logic [31:0] m_pc, m_instr, m_tgt;
  logic        m_have, m_out, m_fault;

  initial begin
    rst = 1'b1; advance = 1'b0; pc_src = 2'b00; imm = '0; rs1 = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Directed table: each row gives the outputs seen this cycle and the inputs driven
    add(0,1,0,0,0,2'b00,0,0, 1,0,0,32'h0,NOP);
    add(0,0,1,32'h0010_0093,0,2'b00,0,0, 0,0,0,32'h0,NOP);
    add(0,0,0,0,1,2'b00,0,0, 0,1,0,32'h0,32'h0010_0093);
    for (int k = 0; k < 3; k++) add(0,0,0,0,0,2'b00,0,0, 1,0,0,32'h4,32'h0010_0093);
    add(0,1,0,0,0,2'b00,0,0, 1,0,0,32'h4,32'h0010_0093);
    add(0,0,0,0,0,2'b00,0,0, 0,0,0,32'h4,32'h0010_0093);
    add(0,0,1,32'hAAAA_0001,1,2'b01,32'h40,0, 0,0,0,32'h4,32'h0010_0093);
    add(0,0,0,0,1,2'b01,32'h4,0, 0,1,0,32'h4,32'hAAAA_0001);
    add(0,1,0,0,0,2'b00,0,0, 1,0,0,32'h8,32'hAAAA_0001);
    add(0,0,1,32'h1111_1111,0,2'b00,0,0, 0,0,0,32'h8,32'hAAAA_0001);
    add(0,0,1,32'h2222_2222,0,2'b00,0,0, 0,1,0,32'h8,32'h1111_1111);
    add(0,0,0,0,1,2'b01,32'hFFFF_FFF8,0, 0,1,0,32'h8,32'h1111_1111);
    add(0,1,0,0,0,2'b00,0,0, 1,0,0,32'h0,32'h1111_1111);
    add(0,0,1,32'h3333_3333,0,2'b00,0,0, 0,0,0,32'h0,32'h1111_1111);
    add(0,0,0,0,1,2'b10,32'h3,32'h101, 0,1,0,32'h0,32'h3333_3333);
    add(0,1,0,0,0,2'b00,0,0, 1,0,0,32'h104,32'h3333_3333);
    add(0,0,1,32'h4444_4444,0,2'b00,0,0, 0,0,0,32'h104,32'h3333_3333);
    add(0,0,0,0,1,2'b11,32'h40,0, 0,1,0,32'h104,32'h4444_4444);
    add(0,1,0,0,0,2'b00,0,0, 1,0,0,32'h108,32'h4444_4444);
    add(0,0,1,32'h5555_5555,0,2'b00,0,0, 0,0,0,32'h108,32'h4444_4444);
    add(0,0,0,0,1,2'b10,32'h2,32'h100, 0,1,0,32'h108,32'h5555_5555);
    for (int k = 0; k < 10; k++) add(0,1,1,32'h6666_6666,1,2'b00,0,0, 0,0,1,32'h108,32'h5555_5555);
    add(1,0,0,0,0,2'b00,0,0, 0,0,1,32'h108,32'h5555_5555);
    add(0,1,0,0,0,2'b00,0,0, 1,0,0,32'h0,NOP);
    add(0,0,1,32'h7777_7777,0,2'b00,0,0, 0,0,0,32'h0,NOP);
    add(0,0,0,0,1,2'b10,32'h0,32'hFFFF_FFFC, 0,1,0,32'h0,32'h7777_7777);
    add(0,1,0,0,0,2'b00,0,0, 1,0,0,32'hFFFF_FFFC,32'h7777_7777);
    add(0,0,1,32'h8888_8888,0,2'b00,0,0, 0,0,0,32'hFFFF_FFFC,32'h7777_7777);
    add(0,0,0,0,1,2'b00,0,0, 0,1,0,32'hFFFF_FFFC,32'h8888_8888);
    add(0,1,0,0,0,2'b00,0,0, 1,0,0,32'h0,32'h8888_8888);
    add(1,0,0,0,0,2'b00,0,0, 0,0,0,32'h0,32'h8888_8888);
    add(0,0,0,0,0,2'b00,0,0, 1,0,0,32'h0,NOP);

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].evalid, tbl[i].emis,
                tbl[i].epc, tbl[i].einstr);
      rst = tbl[i].rst; imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rvalid;
      imem_rdata = tbl[i].rdata; advance = tbl[i].adv; pc_src = tbl[i].src;
      imm = tbl[i].imm; rs1 = tbl[i].rs1;
      @(posedge clk);
    end

    // Randomized traffic against the reference model
    m_pc = '0; m_instr = NOP; m_have = 1'b0; m_out = 1'b0; m_fault = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i > 0)
        check_all("rand", !m_fault && !m_have && !m_out, m_have, m_fault, m_pc, m_instr);
      rst         = (i == 0) || ($urandom_range(0, 63) == 0);
      imem_gnt    = 1'($urandom_range(0, 1));
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      advance     = 1'($urandom_range(0, 1));
      pc_src      = 2'($urandom_range(0, 3));
      imm         = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      rs1         = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      @(posedge clk);
      if (rst) begin
        m_pc = '0; m_instr = NOP; m_have = 1'b0; m_out = 1'b0; m_fault = 1'b0;
      end else if (m_fault) begin
        m_fault = 1'b1;
      end else if (m_out) begin
        if (imem_rvalid) begin
          m_instr = imem_rdata; m_have = 1'b1; m_out = 1'b0;
        end
      end else if (m_have) begin
        if (advance) begin
          if (pc_src == 2'b01)      m_tgt = m_pc + imm;
          else if (pc_src == 2'b10) m_tgt = (rs1 + imm) & 32'hFFFF_FFFE;
          else                      m_tgt = m_pc + 32'd4;
          m_have = 1'b0;
          if (m_tgt % 4 == 0) m_pc = m_tgt;
          else                m_fault = 1'b1;
        end
      end else if (imem_gnt) begin
        m_out = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
